mem_load_unit: RTL

//  Parametrised load path between the pipeline and data memory: accepts a load request,

---
 rtl/mem_load_unit_if.sv | 39 +++
 rtl/mem_load_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_load_unit_if.sv
// Load-unit bus bundle: pipeline request, data-memory read port, result.
// slave = load unit view, master = pipeline/memory/consumer view.
interface mem_load_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_signed;

    logic              mem_rd_valid;
    logic              mem_rd_ready;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_data;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_except;

    modport slave (
        input  req_valid, req_addr, req_size, req_signed,
        input  mem_rd_ready, mem_rsp_valid, mem_rsp_data,
        input  rsp_ready,
        output req_ready, mem_rd_valid, mem_rd_addr,
        output rsp_valid, rsp_data, rsp_except
    );

    modport master (
        output req_valid, req_addr, req_size, req_signed,
        output mem_rd_ready, mem_rsp_valid, mem_rsp_data,
        output rsp_ready,
        input  req_ready, mem_rd_valid, mem_rd_addr,
        input  rsp_valid, rsp_data, rsp_except
    );
endinterface

// File: rtl/mem_load_unit.sv
// Load path: word-aligned memory reads, operand extract, zero/sign extend.
// Ports: clk, rst_b (async active-low), bus (mem_load_unit_if.slave):
//   req_*  : load request (addr, size=log2 bytes, signed)
//   mem_*  : word-aligned read request and read data beat
//   rsp_*  : extended result plus alignment/size exception
// Optional MEM_LOAD_SPLIT_EN: word-crossing loads use two reads instead
// of raising a misalignment exception.
module mem_load_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic            clk,
    input  logic            rst_b,
    mem_load_unit_if.slave  bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int SEL_W = $clog2(2 * DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        WAIT0,
        RD1,
        WAIT1,
        RESP
    } state_e;

    state_e            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              mem_rd_valid_q, mem_rd_valid_d;
    logic [ADDR_W-1:0] mem_rd_addr_q, mem_rd_addr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_except_q, rsp_except_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic              sgn_q, sgn_d;
    logic [DATA_W-1:0] beat0_q, beat0_d;

    logic accept;
    logic size_bad;
    logic illegal;
    logic split_need;

    assign accept   = bus.req_valid & req_ready_q;
    assign size_bad = (32'd8 << bus.req_size) > 32'(DATA_W);

`ifdef MEM_LOAD_SPLIT_EN
    // Crosses into the next word when the last byte lies beyond it.
    assign split_need = (32'(off_q) + (32'd1 << size_q)) > 32'(BYTES);
    assign illegal    = size_bad;
`else
    logic [OFF_W-1:0] amask;
    assign amask      = OFF_W'((32'd1 << bus.req_size) - 32'd1);
    assign split_need = 1'b0;
    assign illegal    = size_bad
                      | (|(bus.req_addr[OFF_W-1:0] & amask));
`endif

    // Shift the two-beat window down to the operand, then extend.
    function automatic logic [DATA_W-1:0] extract(
        input logic [2*DATA_W-1:0] pair,
        input logic [OFF_W-1:0]    off,
        input logic [1:0]          size,
        input logic                sgn
    );
        logic [2*DATA_W-1:0] sh;
        logic [DATA_W-1:0]   res;
        logic                top;
        int unsigned         nb;
        sh  = pair >> {off, 3'b000};
        nb  = 32'd8 << size;
        top = sgn & sh[SEL_W'(nb - 32'd1)];
        for (int i = 0; i < DATA_W; i++) begin
            res[i] = (32'(i) < nb) ? sh[i] : top;
        end
        return res;
    endfunction

    always_comb begin
        state_d        = state_q;
        mem_rd_valid_d = mem_rd_valid_q;
        mem_rd_addr_d  = mem_rd_addr_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_data_d     = rsp_data_q;
        rsp_except_d   = rsp_except_q;
        off_d          = off_q;
        size_d         = size_q;
        sgn_d          = sgn_q;
        beat0_d        = beat0_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    off_d  = bus.req_addr[OFF_W-1:0];
                    size_d = bus.req_size;
                    sgn_d  = bus.req_signed;
                    if (illegal) begin
                        state_d      = RESP;
                        rsp_valid_d  = 1'b1;
                        rsp_except_d = 1'b1;
                        rsp_data_d   = '0;
                    end else begin
                        state_d        = RD0;
                        mem_rd_valid_d = 1'b1;
                        mem_rd_addr_d  = {bus.req_addr[ADDR_W-1:OFF_W],
                                          {OFF_W{1'b0}}};
                    end
                end
            end
            RD0, RD1: begin
                if (bus.mem_rd_ready) begin
                    mem_rd_valid_d = 1'b0;
                    state_d = (state_q == RD0) ? WAIT0 : WAIT1;
                end
            end
            WAIT0: begin
                if (bus.mem_rsp_valid) begin
                    beat0_d = bus.mem_rsp_data;
                    if (split_need) begin
                        state_d        = RD1;
                        mem_rd_valid_d = 1'b1;
                        // Wraps naturally at the top of the address space.
                        mem_rd_addr_d  = mem_rd_addr_q + ADDR_W'(BYTES);
                    end else begin
                        state_d      = RESP;
                        rsp_valid_d  = 1'b1;
                        rsp_except_d = 1'b0;
                        rsp_data_d   = extract(
                            {{DATA_W{1'b0}}, bus.mem_rsp_data},
                            off_q, size_q, sgn_q);
                    end
                end
            end
            WAIT1: begin
                if (bus.mem_rsp_valid) begin
                    state_d      = RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_except_d = 1'b0;
                    rsp_data_d   = extract(
                        {bus.mem_rsp_data, beat0_q},
                        off_q, size_q, sgn_q);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d      = IDLE;
                    rsp_valid_d  = 1'b0;
                    rsp_except_d = 1'b0;
                    rsp_data_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q        <= IDLE;
            req_ready_q    <= 1'b0;
            mem_rd_valid_q <= 1'b0;
            mem_rd_addr_q  <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_data_q     <= '0;
            rsp_except_q   <= 1'b0;
            off_q          <= '0;
            size_q         <= '0;
            sgn_q          <= 1'b0;
            beat0_q        <= '0;
        end else begin
            state_q        <= state_d;
            req_ready_q    <= req_ready_d;
            mem_rd_valid_q <= mem_rd_valid_d;
            mem_rd_addr_q  <= mem_rd_addr_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_data_q     <= rsp_data_d;
            rsp_except_q   <= rsp_except_d;
            off_q          <= off_d;
            size_q         <= size_d;
            sgn_q          <= sgn_d;
            beat0_q        <= beat0_d;
        end
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.mem_rd_valid = mem_rd_valid_q;
    assign bus.mem_rd_addr  = mem_rd_addr_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_except   = rsp_except_q;
endmodule
